key_make_break_decoder: RTL and testbench
=========================================

# key_make_break_decoder

Turns the PS/2 scan-code byte stream into a clean press/release view of one configured key. Sits between the PS/2 byte receiver and the `random` latch in KEYBOARDX. It tracks make, break (F0) and extended (E0) prefixes and suppresses typematic repeats. Its single-cycle `make_pulse` drives the latch's `rise` input, so each physical press captures exactly one random value.

## Interface
- `KEY_CODE`, default 8'h29: final scan-code byte of the tracked key (space).
- `KEY_EXTENDED`, default 1'b0: 1 means the key is only recognised when preceded by E0.
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles after which a pending prefix is discarded (20 ms at 50 MHz). Must be ≥2.
- `clk  in  1`: system clock; the block's single clock.
- `resetN  in  1`: reset, asynchronous and active-low.
- `din  in  8`: scan-code byte from the byte receiver; sampled only when `din_new`=1.
- `din_new  in  1`: one-cycle strobe marking a valid `din`; may be high on consecutive cycles.
- `key_down  out  1`: level, 1 while the key is held.
- `make_pulse  out  1`: one-cycle pulse on the press transition (0→1 of `key_down`).
- `break_pulse  out  1`: one-cycle pulse on the release transition (1→0 of `key_down`).

## Operation
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen). The FSM advances only on `din_new`=1.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Any other byte: make event if `KEY_EXTENDED`=0 and byte = `KEY_CODE`; stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Other byte: make event if `KEY_EXTENDED`=1 and byte matches; → IDLE.
- BRK:
  - E0 → EXT (resynchronise).
  - F0 → stay in BRK.
  - Other byte: break event if `KEY_EXTENDED`=0 and byte matches; → IDLE.
- EXT_BRK:
  - E0 → EXT.
  - F0 → stay in EXT_BRK.
  - Other byte: break event if `KEY_EXTENDED`=1 and byte matches; → IDLE.
- Non-matching codes in any state return the FSM to IDLE and produce no event.
- Make event:
  - If `key_down`=0: set `key_down`=1 and pulse `make_pulse`.
  - If `key_down`=1 (typematic repeat): no output change.
- Break event:
  - If `key_down`=1: clear `key_down` and pulse `break_pulse`.
  - If `key_down`=0 (spurious break): ignored.
- Timeout counter:
  - Cleared on every `din_new`, and held at 0 while in IDLE.
  - Counts up in any other state.
  - On reaching `TIMEOUT_CYCLES`-1: FSM → IDLE, counter → 0, no event, `key_down` unchanged.
  - Counter width is $clog2(`TIMEOUT_CYCLES`). It saturates and never wraps.
- `din` is don't-care while `din_new`=0.
- `make_pulse` and `break_pulse` are never high in the same cycle.

## Timing
- All outputs are registered.
- Latency: `make_pulse`, `break_pulse` and the `key_down` change appear exactly 1 cycle after the clock edge that samples the final code byte with `din_new`=1.
- Pulses are exactly 1 cycle wide, even with back-to-back `din_new`.
- Back-to-back bytes (`din_new` high every cycle) are fully supported. A make in cycle n and a matching break sequence completing at n+2 yields `make_pulse` at n+1 and `break_pulse` at n+3.
- Timeout fires on the clock edge where the counter equals `TIMEOUT_CYCLES`-1. A `din_new` arriving on that same edge wins: the byte is processed normally and the counter clears.
- Reset values: FSM=IDLE, counter=0, `key_down`=0, `make_pulse`=0, `break_pulse`=0.
- Reset mid-sequence discards any prefix. If the key is physically held at reset, the next typematic make produces `make_pulse`, which is the intended recovery.

## Structure
- A shared package (kbd_pkg) holds:
  - Constants SC_EXT=8'hE0 and SC_BRK=8'hF0.
  - The FSM enum typedef, `kbd_prefix_t` {IDLE, EXT, BRK, EXT_BRK}.
  - Common scan-code constants (space 8'h29, arrows E0-75/72/6B/74) for all key decoders.
- Single module; no sub-module. The FSM, timeout counter and key-state/pulse registers live in one file.
- Multiple keys are tracked by instantiating multiple copies with different `KEY_CODE`/`KEY_EXTENDED` values.

## Test plan
- Default parameters, feed 29 → `key_down`=1 and `make_pulse`=1 one cycle later. Then feed F0, 29 → `break_pulse` 1 cycle after the 29 and `key_down`=0.
- Typematic: feed 29 five times, 100 cycles apart → exactly one `make_pulse`, and `key_down` stays 1 throughout.
- Extended key (`KEY_EXTENDED`=1, `KEY_CODE`=8'h75):
  - Feed 75 alone → no event.
  - Feed E0, 75 → make.
  - Feed E0, F0, 75 → break.
  - Feed F0, 75 → no event.
- Timeout (`TIMEOUT_CYCLES`=16): feed F0, wait 16 idle cycles, then feed 29 → treated as a make (FSM returned to IDLE). Then feed F0, wait 10 cycles, feed 29 → break.
- Back-to-back: `din_new` high for 4 consecutive cycles carrying 29, F0, 29, 29 → `make_pulse` at +1, `break_pulse` at +3, second `make_pulse` at +4.
- Reset mid-sequence: feed 29 (held), then E0, assert `resetN`=0 for 2 cycles → all outputs 0. Then feed 29 → `make_pulse`, no spurious `break_pulse`.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared scan-code constants and prefix-FSM encoding for the PS/2 key decoders.
package kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_UP    = 8'h75;   // all arrows need the E0 prefix
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_prefix_t;

endpackage

// File: rtl/key_make_break_decoder.sv
// Tracks one PS/2 key: decodes E0/F0 prefixes, drops typematic repeats,
// and emits a registered key_down level plus single-cycle make/break pulses.
module key_make_break_decoder
    import kbd_pkg::*;
#(
    parameter logic [7:0] KEY_CODE       = SC_SPACE,
    parameter bit         KEY_EXTENDED   = 1'b0,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_new,
    output logic       key_down,
    output logic       make_pulse,
    output logic       break_pulse
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    kbd_prefix_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          key_down_q, key_down_d;
    logic          make_q, make_d;
    logic          brk_q, brk_d;
    logic          match, make_ev, brk_ev;

    assign match = (din == KEY_CODE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_down_d = key_down_q;
        make_d     = 1'b0;
        brk_d      = 1'b0;
        make_ev    = 1'b0;
        brk_ev     = 1'b0;

        if (din_new) begin
            // A byte always wins over a timeout landing on the same edge.
            cnt_d = '0;
            if (din == SC_EXT) begin
                state_d = EXT;
            end else if (din == SC_BRK) begin
                state_d = (state_q == EXT || state_q == EXT_BRK) ? EXT_BRK : BRK;
            end else begin
                state_d = IDLE;
                unique case (state_q)
                    IDLE:    make_ev = !KEY_EXTENDED && match;
                    EXT:     make_ev =  KEY_EXTENDED && match;
                    BRK:     brk_ev  = !KEY_EXTENDED && match;
                    EXT_BRK: brk_ev  =  KEY_EXTENDED && match;
                    default: ;
                endcase
            end
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Repeats while held and breaks while released are swallowed here.
        if (make_ev && !key_down_q) begin
            key_down_d = 1'b1;
            make_d     = 1'b1;
        end
        if (brk_ev && key_down_q) begin
            key_down_d = 1'b0;
            brk_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_down_q <= 1'b0;
            make_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_down_q <= key_down_d;
            make_q     <= make_d;
            brk_q      <= brk_d;
        end
    end

    assign key_down    = key_down_q;
    assign make_pulse  = make_q;
    assign break_pulse = brk_q;

endmodule

// File: tb/tb_key_make_break_decoder.sv
// Bench for key_make_break_decoder: three instances (space, extended up-arrow,
// space with a short timeout) share one byte stream and are checked every cycle.
module tb_key_make_break_decoder;

    logic       clk = 1'b0;
    logic       resetN;
    logic [7:0] din;
    logic       din_new;
    logic [2:0] kd, mk, bk;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_make_break_decoder #(.KEY_CODE(8'h29), .KEY_EXTENDED(1'b0), .TIMEOUT_CYCLES(1_000_000)) u_def (
        .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
        .key_down(kd[0]), .make_pulse(mk[0]), .break_pulse(bk[0]));
    key_make_break_decoder #(.KEY_CODE(8'h75), .KEY_EXTENDED(1'b1), .TIMEOUT_CYCLES(1_000_000)) u_ext (
        .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
        .key_down(kd[1]), .make_pulse(mk[1]), .break_pulse(bk[1]));
    key_make_break_decoder #(.KEY_CODE(8'h29), .KEY_EXTENDED(1'b0), .TIMEOUT_CYCLES(16)) u_to (
        .clk(clk), .resetN(resetN), .din(din), .din_new(din_new),
        .key_down(kd[2]), .make_pulse(mk[2]), .break_pulse(bk[2]));

    // Reference model: pending prefix kept as a string of 'E'/'F' characters.
    logic [7:0]  m_code[3];
    bit          m_ext[3];
    int unsigned m_to[3];
    string       m_pre[3];
    int unsigned m_last[3];
    bit          m_kd[3], m_mk[3], m_bk[3];

    int nchk = 0;
    int nerr = 0;
    int mk0_cnt = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs == exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.key_down", i),    kd[i], m_kd[i]);
            chk($sformatf("u%0d.make_pulse", i),  mk[i], m_mk[i]);
            chk($sformatf("u%0d.break_pulse", i), bk[i], m_bk[i]);
            chk($sformatf("u%0d.exclusive", i),   mk[i] & bk[i], 1'b0);
        end
        if (mk[0]) mk0_cnt++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_pre[i] = "";
            m_kd[i]  = 1'b0;
            m_mk[i]  = 1'b0;
            m_bk[i]  = 1'b0;
        end
    endtask

    task automatic model(input logic v, input logic [7:0] b);
        bit has_e, brk, hit;
        for (int i = 0; i < 3; i++) begin
            m_mk[i] = 1'b0;
            m_bk[i] = 1'b0;
            if (!v) continue;
            // Prefix survives a gap of up to TIMEOUT edges since the last byte.
            if (cyc - m_last[i] > m_to[i]) m_pre[i] = "";
            m_last[i] = cyc;
            if (b == 8'hE0) m_pre[i] = {m_pre[i], "E"};
            else if (b == 8'hF0) m_pre[i] = {m_pre[i], "F"};
            else begin
                has_e = 1'b0;
                brk   = 1'b0;
                for (int k = m_pre[i].len() - 1; k >= 0; k--) begin
                    if (m_pre[i][k] == "E") begin
                        has_e = 1'b1;
                        break;
                    end
                    brk = 1'b1;
                end
                hit = (b == m_code[i]) && (has_e == m_ext[i]);
                if (hit && !brk && !m_kd[i]) begin m_kd[i] = 1'b1; m_mk[i] = 1'b1; end
                if (hit &&  brk &&  m_kd[i]) begin m_kd[i] = 1'b0; m_bk[i] = 1'b1; end
                m_pre[i] = "";
            end
        end
    endtask

    task automatic step(input logic [7:0] b, input logic v);
        @(negedge clk);
        din     = b;
        din_new = v;
        model(v, b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic byte_in(input logic [7:0] b);
        step(b, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'($urandom), 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        resetN  = 1'b0;
        din_new = 1'b0;
        model_clear();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        m_code = '{8'h29, 8'h75, 8'h29};
        m_ext  = '{1'b0, 1'b1, 1'b0};
        m_to   = '{1_000_000, 1_000_000, 16};
        for (int i = 0; i < 3; i++) m_last[i] = 0;
        model_clear();
        resetN  = 1'b0;
        din     = 8'h00;
        din_new = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reset.key_down", kd[i], 1'b0);
            chk("reset.make",     mk[i], 1'b0);
            chk("reset.break",    bk[i], 1'b0);
        end
        @(negedge clk);
        resetN = 1'b1;

        // Basic make / break on space
        byte_in(8'h29);
        chk("basic.make", mk[0], 1'b1);
        chk("basic.down", kd[0], 1'b1);
        idle(3);
        byte_in(8'hF0);
        byte_in(8'h29);
        chk("basic.break", bk[0], 1'b1);
        chk("basic.up",    kd[0], 1'b0);
        idle(3);

        // Typematic repeats produce a single make
        mk0_cnt = 0;
        for (int r = 0; r < 5; r++) begin
            byte_in(8'h29);
            chk("typematic.held", kd[0], 1'b1);
            idle(99);
        end
        chk_int("typematic.make_count", mk0_cnt, 1);

        // Extended key handling
        byte_in(8'h75);
        chk("ext.bare_no_make", mk[1], 1'b0);
        byte_in(8'hE0);
        byte_in(8'h75);
        chk("ext.make", mk[1], 1'b1);
        byte_in(8'hE0);
        byte_in(8'hF0);
        byte_in(8'h75);
        chk("ext.break", bk[1], 1'b1);
        byte_in(8'hF0);
        byte_in(8'h75);
        chk("ext.plain_break_ignored", bk[1], 1'b0);
        chk("ext.still_up", kd[1], 1'b0);

        // Timeout on the 16-cycle instance
        byte_in(8'hF0);
        byte_in(8'h29);
        chk("to.released", kd[2], 1'b0);
        byte_in(8'hF0);
        idle(16);
        byte_in(8'h29);
        chk("to.prefix_dropped_make", mk[2], 1'b1);
        byte_in(8'hF0);
        idle(10);
        byte_in(8'h29);
        chk("to.prefix_kept_break", bk[2], 1'b1);
        idle(2);

        // Back-to-back bytes
        byte_in(8'h29);
        chk("b2b.make1", mk[0], 1'b1);
        byte_in(8'hF0);
        chk("b2b.gap", mk[0] | bk[0], 1'b0);
        byte_in(8'h29);
        chk("b2b.break", bk[0], 1'b1);
        byte_in(8'h29);
        chk("b2b.make2", mk[0], 1'b1);

        // Reset mid-sequence
        byte_in(8'hE0);
        do_reset(2);
        chk("rst.down",  kd[0], 1'b0);
        byte_in(8'h29);
        chk("rst.make",  mk[0], 1'b1);
        chk("rst.nobrk", bk[0], 1'b0);

        // Randomised stream against the model
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: b = 8'h29;
                3, 4:    b = 8'h75;
                5, 6:    b = 8'hE0;
                7, 8:    b = 8'hF0;
                default: b = 8'($urandom);
            endcase
            step(b, $urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) idle($urandom_range(10, 20));
            if ($urandom_range(0, 499) == 0) do_reset(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
